// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  // Counter must reach MEM_LATENCY itself, hence latency+1 codes.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/return and memory-command signals shared by IF, DM, arbiter and memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requesters and memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Chooses the IF/DM winner when the port is free; DM has priority.
// MEM_ARB_STARVE_GUARD_EN adds a DM-streak counter that hands IF a turn.
import mem_arb_pkg::*;

module mem_arb_picker #(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       idle,
  output arb_owner_t winner
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);

  logic [STREAK_W-1:0] streak;
  logic                if_turn_c;

  assign if_turn_c = (streak == STREAK_W'(MAX_DM_STREAK));

  // Counts DM wins taken while IF was waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      streak <= '0;
    end else if (winner == OWN_IF) begin
      streak <= '0;
    end else if (winner == OWN_DM) begin
      streak <= if_req ? streak + STREAK_W'(1) : '0;
    end
  end
`else
  logic if_turn_c;
  logic unused_ok;

  assign if_turn_c = 1'b0;
  assign unused_ok = clock ^ reset ^ (MAX_DM_STREAK == 0);
`endif

  always_comb begin
    winner = OWN_NONE;
    if (idle) begin
      if (dm_req && !(if_req && if_turn_c)) begin
        winner = OWN_DM;
      end else if (if_req) begin
        winner = OWN_IF;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MEM_LATENCY   = 2,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(MEM_LATENCY);
  localparam int unsigned BE_W  = DATA_W / 8;

  arb_state_t        state;
  arb_owner_t        owner;
  logic              owner_store;
  logic [CNT_W-1:0]  cnt;

  logic              done_c;
  logic              idle_c;
  arb_owner_t        winner_c;
  logic              cmd_we_c;
  logic [ADDR_W-1:0] cmd_addr_c;
  logic [DATA_W-1:0] cmd_wdata_c;
  logic [BE_W-1:0]   cmd_be_c;
  logic [DATA_W-1:0] ret_data_c;

  // Completion cycle counts as free so a new grant can overlap it.
  assign done_c = (state == BUSY) && (cnt == CNT_W'(MEM_LATENCY));
  assign idle_c = !reset && ((state == IDLE) || done_c);

  mem_arb_picker #(
    .MAX_DM_STREAK (MAX_DM_STREAK)
  ) u_picker (
    .clock  (clock),
    .reset  (reset),
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .idle   (idle_c),
    .winner (winner_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      owner_store <= 1'b0;
      cnt         <= '0;
    end else if (winner_c != OWN_NONE) begin
      state       <= BUSY;
      owner       <= winner_c;
      owner_store <= (winner_c == OWN_DM) && bus.dm_we;
      cnt         <= CNT_W'(1);
    end else if ((state == IDLE) || done_c) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      owner_store <= 1'b0;
      cnt         <= '0;
    end else begin
      cnt         <= cnt + CNT_W'(1);
    end
  end

  // Grant strobes and memory command from the winner's payload.
  always_comb begin
    bus.if_gnt  = 1'b0;
    bus.dm_gnt  = 1'b0;
    cmd_we_c    = 1'b0;
    cmd_addr_c  = '0;
    cmd_wdata_c = '0;
    cmd_be_c    = '0;
    case (winner_c)
      OWN_IF: begin
        bus.if_gnt = 1'b1;
        cmd_addr_c = bus.if_addr;
      end
      OWN_DM: begin
        bus.dm_gnt  = 1'b1;
        cmd_we_c    = bus.dm_we;
        cmd_addr_c  = bus.dm_addr;
        cmd_wdata_c = bus.dm_wdata;
        cmd_be_c    = bus.dm_be;
      end
      default: ;
    endcase
    bus.mem_en    = (winner_c != OWN_NONE);
    bus.mem_we    = cmd_we_c;
    bus.mem_addr  = cmd_addr_c;
    bus.mem_wdata = cmd_wdata_c;
    bus.mem_be    = cmd_be_c;
  end

  assign ret_data_c = bus.mem_rdata;

  // Return steering: only the owner sees data, and only in the completion cycle.
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_rvalid = 1'b0;
    bus.dm_rdata  = '0;
    if (done_c && !reset) begin
      case (owner)
        OWN_IF: begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = ret_data_c;
        end
        OWN_DM: begin
          bus.dm_rvalid = 1'b1;
          bus.dm_rdata  = owner_store ? '0 : ret_data_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level model plus a latency-1 directed check.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          LAT  = 2;
  localparam int          MAXS = 4;

  typedef struct {
    int          own;   // 0 none, 1 IF, 2 DM
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gexp_t;

  typedef struct {
    int          due;
    int          own;
    logic        store;
    logic [31:0] word;
  } rexp_t;

  logic clock = 1'b0;
  logic reset;
  logic reset1;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_DM_STREAK(MAXS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .MAX_DM_STREAK(MAXS)
  ) dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (bus1)
  );

  gexp_t gnt_q[$];
  rexp_t rsp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    free_at = 0;
  int    streak = 0;
  int    last_win = 0;

  logic        if_pend = 1'b0;
  logic        dm_pend = 1'b0;
  logic [31:0] if_a = '0;
  logic        dm_w = 1'b0;
  logic [31:0] dm_a = '0;
  logic [31:0] dm_d = '0;
  logic [3:0]  dm_b = '0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2402_000A;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model decides the grant and queues the expected responses.
  task automatic step(input logic rst, input logic wi, input logic wd, input logic we,
                      input logic [3:0] be, input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] dw);
    gexp_t g;
    rexp_t r;
    int    win;
    logic  hit;
    @(posedge clock);
    #1;
    cyc++;
    if (last_win == 1) if_pend = 1'b0;
    if (last_win == 2) dm_pend = 1'b0;
    if (wi && !if_pend) begin
      if_pend = 1'b1;
      if_a    = ia;
    end
    if (wd && !dm_pend) begin
      dm_pend = 1'b1;
      dm_w    = we;
      dm_a    = da;
      dm_d    = dw;
      dm_b    = be;
    end
    win = 0;
    hit = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    hit = (streak >= MAXS);
`endif
    if (rst) begin
      rsp_q.delete();
      free_at = cyc + 1;
      streak  = 0;
    end else if (cyc >= free_at && (if_pend || dm_pend)) begin
      win     = (dm_pend && !(if_pend && hit)) ? 2 : 1;
      streak  = (win == 2 && if_pend) ? streak + 1 : 0;
      free_at = cyc + LAT;
      r.due   = cyc + LAT;
      r.own   = win;
      r.store = (win == 2) && dm_w;
      r.word  = memword(win == 1 ? if_a : dm_a);
      rsp_q.push_back(r);
    end
    g.own   = win;
    g.we    = (win == 2) && dm_w;
    g.addr  = (win == 1) ? if_a : ((win == 2) ? dm_a : 32'h0);
    g.wdata = (win == 2) ? dm_d : 32'h0;
    g.be    = (win == 2) ? dm_b : 4'h0;
    gnt_q.push_back(g);
    last_win = win;

    reset        = rst;
    bus.if_req   = if_pend;
    bus.if_addr  = if_a;
    bus.dm_req   = dm_pend;
    bus.dm_we    = dm_w;
    bus.dm_addr  = dm_a;
    bus.dm_wdata = dm_d;
    bus.dm_be    = dm_b;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc && !rsp_q[0].store)
      bus.mem_rdata = rsp_q[0].word;
    else
      bus.mem_rdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  gexp_t mg;
  rexp_t mr;

  // Monitor: pops the expected grant every cycle and the expected return when due.
  always @(negedge clock) begin
    if (gnt_q.size() > 0) begin
      mg = gnt_q.pop_front();
      chk("grant{ifg,dmg,en,we,be}",
          64'({bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.mem_we, bus.mem_be}),
          64'({mg.own == 1, mg.own == 2, mg.own != 0, mg.we, mg.be}));
      chk("mem_addr", 64'(bus.mem_addr), 64'(mg.addr));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(mg.wdata));
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        mr = rsp_q.pop_front();
      end else begin
        mr.due = 0; mr.own = 0; mr.store = 1'b0; mr.word = '0;
      end
      chk("rvalid{if,dm}", 64'({bus.if_rvalid, bus.dm_rvalid}),
          64'({mr.own == 1, mr.own == 2}));
      chk("if_rdata", 64'(bus.if_rdata), 64'(mr.own == 1 ? mr.word : 32'h0));
      chk("dm_rdata", 64'(bus.dm_rdata),
          64'((mr.own == 2 && !mr.store) ? mr.word : 32'h0));
    end
  end

  logic [31:0] a1;
  logic [31:0] prev1;

  initial begin
    reset = 1'b1;
    reset1 = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0; bus.mem_rdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    bus1.dm_addr = '0; bus1.dm_wdata = '0; bus1.dm_be = '0; bus1.mem_rdata = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    idle(1);

    // Single fetch
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0040_0000, 32'h0, 32'h0);
    idle(3);
    // Simultaneous fetch and load
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0040_0004, 32'h1001_0000, 32'h0);
    idle(5);
    // Store
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h1001_0004, 32'hDEAD_BEEF);
    idle(3);
    // Both held continuously
    for (int i = 0; i < 24; i++)
      step(1'b0, 1'b1, 1'b1, 1'($urandom_range(1)), 4'($urandom), 32'h0040_0000 + 32'(4 * i),
           32'h1001_0000 + 32'(4 * i), $urandom);
    idle(3);
    // Reset the cycle after a load grant, then fetch
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h1001_0008, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0040_0010, 32'h0, 32'h0);
    idle(3);
    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) == 0, $urandom_range(99) < 60, $urandom_range(99) < 50,
           1'($urandom_range(1)), 4'($urandom), $urandom & 32'hFFFF_FFFC,
           $urandom & 32'hFFFF_FFFC, $urandom);
    idle(4);
    @(negedge clock);
    #1;

    // Latency-1 instance: fetch held, grant and return every cycle
    @(posedge clock); #1;
    reset1 = 1'b0;
    prev1 = '0;
    for (int i = 0; i < 10; i++) begin
      a1 = 32'h0040_0100 + 32'(4 * i);
      bus1.if_req    = 1'b1;
      bus1.if_addr   = a1;
      bus1.mem_rdata = (i > 0) ? memword(prev1) : $urandom;
      @(negedge clock);
      chk("l1_if_gnt", 64'({bus1.if_gnt, bus1.dm_gnt, bus1.mem_en, bus1.mem_we}), 64'(4'b1010));
      chk("l1_mem_addr", 64'(bus1.mem_addr), 64'(a1));
      chk("l1_if_rvalid", 64'({bus1.if_rvalid, bus1.dm_rvalid}), 64'((i > 0) ? 2'b10 : 2'b00));
      chk("l1_if_rdata", 64'(bus1.if_rdata), 64'((i > 0) ? memword(prev1) : 32'h0));
      prev1 = a1;
      @(posedge clock); #1;
    end
    bus1.if_req = 1'b0;
    @(negedge clock);
    chk("l1_last_return", 64'({bus1.if_rvalid, bus1.if_gnt}), 64'(2'b10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single unified memory port of the MIPS core between the instruction-fetch requester (IF) and the data-memory requester (DM, the load/store stage). It sits between the pipeline stages and the memory inside `TopLevel`. It keeps at most one transaction in flight and tracks it for a fixed memory latency. It returns read data or write acknowledgement to the owning requester.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 2, cycles from `mem_en` to valid `mem_rdata` (>= 1)
- `MAX_DM_STREAK`, 4, consecutive DM grants allowed while IF waits (guard build only, >= 1)

Ports:
- `clock` in 1: the only clock
- `reset` in 1: synchronous, active-high
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`
- `if_addr` in ADDR_W: fetch address
- `if_gnt` out 1: request accepted this cycle
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid
- `if_rdata` out DATA_W: fetched word
- `dm_req` in 1: data request; held with its payload until `dm_gnt`
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in ADDR_W: data address
- `dm_wdata` in DATA_W: store data
- `dm_be` in DATA_W/8: store byte enables
- `dm_gnt` out 1: data request accepted
- `dm_rvalid` out 1: completion pulse for load and store
- `dm_rdata` out DATA_W: load data; 0 for stores
- `mem_en`, `mem_we` out 1: memory strobe and write enable
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_be` out DATA_W/8: memory command
- `mem_rdata` in DATA_W: memory read data, valid MEM_LATENCY cycles after `mem_en`

## Operation
- States are IDLE and BUSY. `owner` is one of NONE, IF or DM, and a latency counter `cnt` tracks the transaction.
- In IDLE, when at least one request is present, one winner is granted combinationally:
  - The winner's `*_gnt` is driven high.
  - `mem_en` is driven high, with `mem_*` copied from the winner's payload. IF commands always have `mem_we`=0 and `mem_be`=0.
  - On the next edge the arbiter records `owner` and enters BUSY.
- Priority: DM beats IF, because the older instruction goes first.
- While in BUSY, no grant is issued, `mem_en`=0 and `cnt` increments.
- In the completion cycle (`cnt`==MEM_LATENCY), the owner's `*_rvalid`=1 and `*_rdata`=`mem_rdata`. DM stores return `dm_rdata`=0.
  - The arbiter counts as IDLE in that same cycle, so a new grant may coincide with the completion.
- MEM_LATENCY=1: no BUSY cycles; back-to-back grants every cycle.
- Outside `*_rvalid`, `*_rdata` are 0.
- The arbiter never pulses `gnt` twice for one held request. A requester deasserts `req` or changes its payload in the cycle after `gnt`.
- Reset values: all outputs 0, state IDLE, `owner` NONE, `cnt` 0, streak 0.
- Reset mid-transaction: the in-flight transaction is dropped and no `rvalid` is ever issued for it.
- `reset` and `req` high in the same cycle: no grant.

## Timing
- Grant in cycle T, `rvalid` in cycle T+MEM_LATENCY.
- Sustained throughput: one transaction per MEM_LATENCY cycles.
- `gnt` and `mem_*` are combinational from `req` and state.
- `rvalid` and `rdata` are combinational from the registered owner/count and `mem_rdata`.
- No combinational path from `mem_rdata` to any `gnt`.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A streak counter (width clog2(MAX_DM_STREAK+1)) increments on each DM grant made while `if_req`=1.
  - It clears on any IF grant, and on any DM grant made while `if_req`=0.
  - When the streak equals MAX_DM_STREAK and both requesters are present, IF wins.
- `MEM_ARB_STARVE_GUARD_EN` undefined: strict DM priority, and no counter is present.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` {IDLE, BUSY}
  - `arb_owner_t` {OWN_NONE, OWN_IF, OWN_DM}
  - a function returning the latency-counter width
- One sub-module, `mem_arb_picker`:
  - holds the priority logic and the streak counter (present only in the guard build)
  - inputs: `if_req`, `dm_req`, `idle`; output: the winner
- `mem_port_arbiter` holds the FSM, the counter, the payload mux and the return steering.

## Test plan
- Single IF read: MEM_LATENCY=2, `if_addr`=0x00400000, memory returns 0x2402000A.
  - `if_gnt` in cycle T, `mem_en`=1 with `mem_we`=0 in T, `if_rvalid`=1 with `if_rdata`=0x2402000A in T+2.
  - `dm_*` outputs stay 0 throughout.
- Simultaneous requests: IF fetch plus DM load of 0x10010000 in the same cycle.
  - `dm_gnt` first and `if_gnt` 2 cycles later.
  - Each `rvalid` goes only to its own requester.
- DM store: `dm_we`=1, `dm_be`=0xF, `dm_wdata`=0xDEADBEEF.
  - `mem_we`=1 and `mem_wdata`=0xDEADBEEF in the grant cycle.
  - `dm_rvalid`=1 with `dm_rdata`=0 two cycles later.
- Starvation: guard build, MAX_DM_STREAK=4, `if_req` and `dm_req` held high continuously.
  - Grant order is DM,DM,DM,DM,IF, repeating.
  - Without the macro, DM is granted every time.
- Reset mid-transaction: `reset` asserted the cycle after a DM load grant.
  - No `dm_rvalid` ever appears.
  - All outputs are 0 in the cycle after reset.
  - A new IF request after reset is granted immediately.
- MEM_LATENCY=1 with IF held: `if_gnt` every cycle and `if_rvalid` every cycle starting one cycle after the first grant.
